wt_mem_arbiter: RTL and testbench

- Memory-side stage placed directly downstream of the write-through I$/D$ pair, between the caches and the bus adapter.
- Arbitrates I$ refill requests and D$ load/store/AMO requests onto one tagged memory request channel.
- Tracks up to MaxOutstanding transactions in a tag table.
- Routes each tagged response back to the originating cache with that cache's original transaction ID.

---
 rtl/wt_cache_pkg.sv | 32 +++
 rtl/wt_mem_tag_table.sv | 78 +++++++
 rtl/wt_mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_wt_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// rtl/wt_cache_pkg.sv - shared types for the write-through cache memory-side stage
//
// Holds the memory request type encoding, the full-line size code and the
// tag table entry layout used by wt_mem_arbiter and wt_mem_tag_table.
package wt_cache_pkg;

  typedef enum logic [1:0] {
    MEM_LOAD  = 2'b00,
    MEM_STORE = 2'b01,
    MEM_AMO   = 2'b10,
    MEM_IFILL = 2'b11
  } mem_req_type_e;

  // Size code marking a full I$ line transfer.
  localparam logic [2:0] LINE_SIZE = 3'b111;

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_DC = 1'b1
  } src_e;

  // Width of the cache-side transaction ID held in a tag entry. The arbiter's
  // TidWidth parameter defaults to this; widen it here to carry wider IDs.
  localparam int unsigned CACHE_TID_WIDTH = 2;

  typedef struct packed {
    logic                       valid;
    src_e                       src;
    logic [CACHE_TID_WIDTH-1:0] tid;
  } tag_entry_t;

endpackage

// File: rtl/wt_mem_tag_table.sv
// rtl/wt_mem_tag_table.sv - outstanding transaction tag table
//
// Purpose: records {src, tid} per memory tag while a transaction is in
// flight; finds the lowest free tag and reports when no tag is free.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (clears all entries)
//   alloc_i          write alloc_entry_i into entry alloc_idx_o at the edge
//   alloc_entry_i    entry contents to store
//   alloc_idx_o      lowest-index free tag (valid when full_o is 0)
//   full_o           no free tag this cycle
//   free_i           invalidate entry free_idx_i at the edge
//   free_idx_i       tag to free
//   lookup_idx_i     tag to read
//   lookup_o         entry at lookup_idx_i
//   valid_o          per-tag valid bits
module wt_mem_tag_table
  import wt_cache_pkg::*;
#(
  parameter int unsigned  MaxOutstanding = 4,
  localparam int unsigned TagWidth       = $clog2(MaxOutstanding)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      alloc_i,
  input  tag_entry_t                alloc_entry_i,
  output logic [TagWidth-1:0]       alloc_idx_o,
  output logic                      full_o,
  input  logic                      free_i,
  input  logic [TagWidth-1:0]       free_idx_i,
  input  logic [TagWidth-1:0]       lookup_idx_i,
  output tag_entry_t                lookup_o,
  output logic [MaxOutstanding-1:0] valid_o
);

  tag_entry_t [MaxOutstanding-1:0] entry_q, entry_d;

  // The free finder looks only at the registered valid bits, so a tag being
  // freed this cycle cannot be handed out again until the next cycle, and the
  // alloc and free targets can never collide.
  always_comb begin
    alloc_idx_o = '0;
    full_o      = 1'b1;
    for (int i = int'(MaxOutstanding) - 1; i >= 0; i--) begin
      if (!entry_q[i].valid) begin
        alloc_idx_o = TagWidth'(i);
        full_o      = 1'b0;
      end
    end
  end

  always_comb begin
    entry_d = entry_q;
    if (free_i) begin
      entry_d[free_idx_i].valid = 1'b0;
    end
    if (alloc_i) begin
      entry_d[alloc_idx_o] = alloc_entry_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign lookup_o = entry_q[lookup_idx_i];

  always_comb begin
    valid_o = '0;
    for (int i = 0; i < int'(MaxOutstanding); i++) begin
      valid_o[i] = entry_q[i].valid;
    end
  end

endmodule

// File: rtl/wt_mem_arbiter.sv
// rtl/wt_mem_arbiter.sv - I$/D$ arbiter onto one tagged memory request channel
//
// Purpose: grants I$ refills and D$ load/store/AMO requests round-robin into
// a single request holding register, tags each with the lowest free table
// entry, and routes tagged responses back to the originating cache with its
// original transaction ID.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   ic_*                  I$ request (held until ic_ack_o pulse)
//   dc_*                  D$ request (held until dc_ack_o pulse)
//   mem_req_*             registered tagged request, valid/ready handshake
//   mem_rsp_*             tagged response, no backpressure
//   ic_rtrn_*, dc_rtrn_*  same-cycle return pulses with original tid
//   rtrn_data_o           return data shared by both caches
//   busy_o                request register or any tag occupied
//   err_o                 sticky: response arrived for an unallocated tag
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned  AddrWidth      = 64,
  parameter int unsigned  DataWidth      = 64,
  parameter int unsigned  LineWidth      = 128,
  parameter int unsigned  TidWidth       = CACHE_TID_WIDTH,
  parameter int unsigned  MaxOutstanding = 4,
  localparam int unsigned TagWidth       = $clog2(MaxOutstanding)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ic_req_i,
  output logic                   ic_ack_o,
  input  logic [AddrWidth-1:0]   ic_addr_i,
  input  logic [TidWidth-1:0]    ic_tid_i,
  input  logic                   dc_req_i,
  output logic                   dc_ack_o,
  input  logic [1:0]             dc_type_i,
  input  logic [AddrWidth-1:0]   dc_addr_i,
  input  logic [2:0]             dc_size_i,
  input  logic [DataWidth-1:0]   dc_data_i,
  input  logic [DataWidth/8-1:0] dc_be_i,
  input  logic [TidWidth-1:0]    dc_tid_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [1:0]             mem_req_type_o,
  output logic [AddrWidth-1:0]   mem_req_addr_o,
  output logic [2:0]             mem_req_size_o,
  output logic [DataWidth-1:0]   mem_req_data_o,
  output logic [DataWidth/8-1:0] mem_req_be_o,
  output logic [TagWidth-1:0]    mem_req_tag_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [TagWidth-1:0]    mem_rsp_tag_i,
  input  logic [LineWidth-1:0]   mem_rsp_data_i,
  output logic                   ic_rtrn_vld_o,
  output logic [TidWidth-1:0]    ic_rtrn_tid_o,
  output logic                   dc_rtrn_vld_o,
  output logic [TidWidth-1:0]    dc_rtrn_tid_o,
  output logic [LineWidth-1:0]   rtrn_data_o,
  output logic                   busy_o,
  output logic                   err_o
);

  typedef struct packed {
    logic                   valid;
    mem_req_type_e          typ;
    logic [AddrWidth-1:0]   addr;
    logic [2:0]             size;
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] be;
    logic [TagWidth-1:0]    tag;
  } req_t;

  req_t                      req_q, req_d;
  src_e                      rr_q, rr_d;
  logic                      err_q, err_d;
  logic [TagWidth:0]         outstanding_q, outstanding_d;

  logic                      alloc;
  tag_entry_t                alloc_entry;
  logic [TagWidth-1:0]       alloc_idx;
  logic                      tbl_full;
  logic                      rsp_hit;
  tag_entry_t                lookup;
  logic [MaxOutstanding-1:0] tag_valid;
  logic                      can_grant;

  wt_mem_tag_table #(
    .MaxOutstanding(MaxOutstanding)
  ) u_tag_table (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alloc_i      (alloc),
    .alloc_entry_i(alloc_entry),
    .alloc_idx_o  (alloc_idx),
    .full_o       (tbl_full),
    .free_i       (rsp_hit),
    .free_idx_i   (mem_rsp_tag_i),
    .lookup_idx_i (mem_rsp_tag_i),
    .lookup_o     (lookup),
    .valid_o      (tag_valid)
  );

  // A response only counts when its tag is live; nothing is returned while
  // reset is asserted, so in-flight transactions are silently dropped.
  assign rsp_hit = mem_rsp_valid_i && lookup.valid && !rst_i;

  // The holding register can take a new request when it is empty or is
  // being drained by the downstream handshake in this same cycle.
  assign can_grant = !rst_i && !tbl_full && (!req_q.valid || mem_req_ready_i);

  always_comb begin
    req_d       = req_q;
    rr_d        = rr_q;
    err_d       = err_q;
    ic_ack_o    = 1'b0;
    dc_ack_o    = 1'b0;
    alloc       = 1'b0;
    alloc_entry = '0;

    if (req_q.valid && mem_req_ready_i) begin
      req_d.valid = 1'b0;
    end

    if (can_grant && (ic_req_i || dc_req_i)) begin
      alloc             = 1'b1;
      alloc_entry.valid = 1'b1;
      req_d.valid       = 1'b1;
      req_d.tag         = alloc_idx;
      // D$ wins when it is alone or when the pointer currently favours it.
      if (dc_req_i && (!ic_req_i || rr_q == SRC_DC)) begin
        dc_ack_o        = 1'b1;
        alloc_entry.src = SRC_DC;
        alloc_entry.tid = CACHE_TID_WIDTH'(dc_tid_i);
        req_d.typ       = mem_req_type_e'(dc_type_i);
        req_d.addr      = dc_addr_i;
        req_d.size      = dc_size_i;
        req_d.data      = dc_data_i;
        req_d.be        = dc_be_i;
        rr_d            = SRC_IC;
      end else begin
        ic_ack_o        = 1'b1;
        alloc_entry.src = SRC_IC;
        alloc_entry.tid = CACHE_TID_WIDTH'(ic_tid_i);
        req_d.typ       = MEM_IFILL;
        req_d.addr      = ic_addr_i;
        req_d.size      = LINE_SIZE;
        req_d.data      = '0;
        req_d.be        = '0;
        rr_d            = SRC_DC;
      end
    end

    if (mem_rsp_valid_i && !lookup.valid) begin
      err_d = 1'b1;
    end
  end

  // Alloc and free never target the same tag, so the count moves by at most
  // one in either direction and stays equal to the number of live entries.
  always_comb begin
    outstanding_d = outstanding_q + (TagWidth+1)'(alloc) - (TagWidth+1)'(rsp_hit);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q         <= '0;
      rr_q          <= SRC_IC;
      err_q         <= 1'b0;
      outstanding_q <= '0;
    end else begin
      req_q         <= req_d;
      rr_q          <= rr_d;
      err_q         <= err_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign mem_req_valid_o = req_q.valid;
  assign mem_req_type_o  = req_q.typ;
  assign mem_req_addr_o  = req_q.addr;
  assign mem_req_size_o  = req_q.size;
  assign mem_req_data_o  = req_q.data;
  assign mem_req_be_o    = req_q.be;
  assign mem_req_tag_o   = req_q.tag;

  assign ic_rtrn_vld_o = rsp_hit && (lookup.src == SRC_IC);
  assign dc_rtrn_vld_o = rsp_hit && (lookup.src == SRC_DC);
  assign ic_rtrn_tid_o = ic_rtrn_vld_o ? TidWidth'(lookup.tid) : '0;
  assign dc_rtrn_tid_o = dc_rtrn_vld_o ? TidWidth'(lookup.tid) : '0;
  assign rtrn_data_o   = rsp_hit ? mem_rsp_data_i : '0;

  assign busy_o = req_q.valid || (|tag_valid);
  assign err_o  = err_q;

  a_outstanding_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding_q <= (TagWidth+1)'(MaxOutstanding));

  a_outstanding_match : assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding_q == (TagWidth+1)'($countones(tag_valid)));

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// tb/tb_wt_mem_arbiter.sv - scoreboard bench for wt_mem_arbiter
module tb_wt_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 128;
  localparam int TW = 2;
  localparam int MO = 4;
  localparam int GW = 2;

  typedef struct {
    logic [1:0]      typ;
    logic [AW-1:0]   addr;
    logic [2:0]      size;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
    logic [TW-1:0]   tid;
    logic [GW-1:0]   tag;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            ic_req, ic_ack_o;
  logic [AW-1:0]   ic_addr;
  logic [TW-1:0]   ic_tid;
  logic            dc_req, dc_ack_o;
  logic [1:0]      dc_type;
  logic [AW-1:0]   dc_addr;
  logic [2:0]      dc_size;
  logic [DW-1:0]   dc_data;
  logic [DW/8-1:0] dc_be;
  logic [TW-1:0]   dc_tid;
  logic            mem_req_valid_o, ready;
  logic [1:0]      mem_req_type_o;
  logic [AW-1:0]   mem_req_addr_o;
  logic [2:0]      mem_req_size_o;
  logic [DW-1:0]   mem_req_data_o;
  logic [DW/8-1:0] mem_req_be_o;
  logic [GW-1:0]   mem_req_tag_o;
  logic            rsp_valid;
  logic [GW-1:0]   rsp_tag;
  logic [LW-1:0]   rsp_data;
  logic            ic_rtrn_vld_o, dc_rtrn_vld_o;
  logic [TW-1:0]   ic_rtrn_tid_o, dc_rtrn_tid_o;
  logic [LW-1:0]   rtrn_data_o;
  logic            busy_o, err_o;

  wt_mem_arbiter #(
    .AddrWidth(AW), .DataWidth(DW), .LineWidth(LW), .TidWidth(TW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .ic_req_i(ic_req), .ic_ack_o(ic_ack_o), .ic_addr_i(ic_addr), .ic_tid_i(ic_tid),
    .dc_req_i(dc_req), .dc_ack_o(dc_ack_o), .dc_type_i(dc_type), .dc_addr_i(dc_addr),
    .dc_size_i(dc_size), .dc_data_i(dc_data), .dc_be_i(dc_be), .dc_tid_i(dc_tid),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(ready),
    .mem_req_type_o(mem_req_type_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_size_o(mem_req_size_o), .mem_req_data_o(mem_req_data_o),
    .mem_req_be_o(mem_req_be_o), .mem_req_tag_o(mem_req_tag_o),
    .mem_rsp_valid_i(rsp_valid), .mem_rsp_tag_i(rsp_tag), .mem_rsp_data_i(rsp_data),
    .ic_rtrn_vld_o(ic_rtrn_vld_o), .ic_rtrn_tid_o(ic_rtrn_tid_o),
    .dc_rtrn_vld_o(dc_rtrn_vld_o), .dc_rtrn_tid_o(dc_rtrn_tid_o),
    .rtrn_data_o(rtrn_data_o), .busy_o(busy_o), .err_o(err_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] expv);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model state: what the spec says the table, pointer and
  // holding register contain after each clock edge.
  logic [MO-1:0] m_valid;
  bit            m_src [MO];
  logic [TW-1:0] m_tid [MO];
  bit            m_rr;
  bit            m_err;
  txn_t          exp_q[$];
  logic [GW-1:0] issued[$];

  txn_t ic_q[$], dc_q[$];
  txn_t ic_cur, dc_cur;
  bit   ic_ack_seen, dc_ack_seen;

  always @(negedge clk) begin : monitor
    int fidx;
    bit gi, gd, ei, ed;
    logic [TW-1:0] etid;
    txn_t e;
    ic_ack_seen = ic_ack_o;
    dc_ack_seen = dc_ack_o;
    if (rst) begin
      chk(!ic_ack_o && !dc_ack_o && !ic_rtrn_vld_o && !dc_rtrn_vld_o, "rst_pulses",
          {ic_ack_o, dc_ack_o, ic_rtrn_vld_o, dc_rtrn_vld_o}, 0);
      m_valid = '0; m_rr = 0; m_err = 0;
      exp_q.delete(); issued.delete();
    end else begin
      fidx = -1;
      for (int i = MO - 1; i >= 0; i--) if (!m_valid[i]) fidx = i;
      gi = 0; gd = 0;
      if ((ic_req || dc_req) && (exp_q.size() == 0 || ready) && fidx >= 0) begin
        if (dc_req && (!ic_req || m_rr)) gd = 1; else gi = 1;
      end
      chk(ic_ack_o === gi, "ic_ack", ic_ack_o, gi);
      chk(dc_ack_o === gd, "dc_ack", dc_ack_o, gd);

      ei = 0; ed = 0; etid = '0;
      if (rsp_valid && m_valid[rsp_tag]) begin
        ed = m_src[rsp_tag]; ei = !ed; etid = m_tid[rsp_tag];
      end
      chk(ic_rtrn_vld_o === ei, "ic_rtrn_vld", ic_rtrn_vld_o, ei);
      chk(dc_rtrn_vld_o === ed, "dc_rtrn_vld", dc_rtrn_vld_o, ed);
      if (ei) chk(ic_rtrn_tid_o === etid, "ic_rtrn_tid", ic_rtrn_tid_o, etid);
      if (ed) chk(dc_rtrn_tid_o === etid, "dc_rtrn_tid", dc_rtrn_tid_o, etid);
      if (ei || ed) chk(rtrn_data_o === rsp_data, "rtrn_data", rtrn_data_o, rsp_data);

      chk(mem_req_valid_o === (exp_q.size() != 0), "req_valid", mem_req_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk(mem_req_type_o === e.typ, "req_type", mem_req_type_o, e.typ);
        chk(mem_req_addr_o === e.addr, "req_addr", mem_req_addr_o, e.addr);
        chk(mem_req_size_o === e.size, "req_size", mem_req_size_o, e.size);
        chk(mem_req_data_o === e.data, "req_data", mem_req_data_o, e.data);
        chk(mem_req_be_o === e.be, "req_be", mem_req_be_o, e.be);
        chk(mem_req_tag_o === e.tag, "req_tag", mem_req_tag_o, e.tag);
      end
      chk(busy_o === (exp_q.size() != 0 || m_valid != 0), "busy", busy_o, exp_q.size() != 0 || m_valid != 0);
      chk(err_o === m_err, "err", err_o, m_err);

      // Advance the model to the state after the coming edge.
      if (mem_req_valid_o && ready && exp_q.size() != 0) begin
        issued.push_back(exp_q[0].tag);
        void'(exp_q.pop_front());
      end
      if (rsp_valid) begin
        if (m_valid[rsp_tag]) m_valid[rsp_tag] = 1'b0;
        else m_err = 1;
      end
      if (gi || gd) begin
        e = gi ? ic_cur : dc_cur;
        e.tag = GW'(fidx);
        m_valid[fidx] = 1'b1;
        m_src[fidx] = gd;
        m_tid[fidx] = e.tid;
        exp_q.push_back(e);
        m_rr = gi;
      end
    end
  end

  // Request drivers: hold each request until the ack pulse, then present the next.
  initial begin
    ic_req = 0; ic_addr = '0; ic_tid = '0;
    forever begin
      @(posedge clk); #2;
      if (rst || ic_ack_seen) ic_req = 0;
      if (!rst && !ic_req && ic_q.size() != 0) begin
        ic_cur = ic_q.pop_front();
        ic_req = 1; ic_addr = ic_cur.addr; ic_tid = ic_cur.tid;
      end
    end
  end

  initial begin
    dc_req = 0; dc_type = '0; dc_addr = '0; dc_size = '0; dc_data = '0; dc_be = '0; dc_tid = '0;
    forever begin
      @(posedge clk); #2;
      if (rst || dc_ack_seen) dc_req = 0;
      if (!rst && !dc_req && dc_q.size() != 0) begin
        dc_cur = dc_q.pop_front();
        dc_req = 1; dc_type = dc_cur.typ; dc_addr = dc_cur.addr; dc_size = dc_cur.size;
        dc_data = dc_cur.data; dc_be = dc_cur.be; dc_tid = dc_cur.tid;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    rsp_valid = 0;
  endtask

  task automatic push_ic(input logic [AW-1:0] addr, input logic [TW-1:0] tid);
    txn_t t;
    t.typ = 2'b11; t.addr = addr; t.size = 3'b111; t.data = '0; t.be = '0; t.tid = tid; t.tag = '0;
    ic_q.push_back(t);
  endtask

  task automatic push_dc(input logic [1:0] typ, input logic [TW-1:0] tid);
    txn_t t;
    t.typ = typ; t.addr = {$urandom(), $urandom()}; t.size = 3'($urandom_range(3));
    t.data = {$urandom(), $urandom()}; t.be = 8'($urandom()); t.tid = tid; t.tag = '0;
    dc_q.push_back(t);
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send_rsp(input logic [GW-1:0] tag, input logic [LW-1:0] data);
    rsp_valid = 1; rsp_tag = tag; rsp_data = data;
    for (int i = 0; i < issued.size(); i++) begin
      if (issued[i] == tag) begin
        issued.delete(i);
        break;
      end
    end
  endtask

  task automatic wait_issued(input int n);
    int i;
    for (i = 0; i < 50 && issued.size() < n; i++) cyc();
    chk(issued.size() >= n, "wait_issued", issued.size(), n);
  endtask

  task automatic drain();
    bit done;
    ready = 1;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      done = ic_q.size() == 0 && dc_q.size() == 0 && !ic_req && !dc_req &&
             exp_q.size() == 0 && m_valid == 0;
      if (done) break;
      cyc();
      if (issued.size() != 0) send_rsp(issued[0], rnd_line());
    end
    chk(done, "drain", done, 1);
  endtask

  task automatic check_idle();
    @(negedge clk);
    chk({mem_req_valid_o, mem_req_type_o, mem_req_addr_o, mem_req_size_o, mem_req_tag_o} == 0,
        "idle_req", {mem_req_valid_o, mem_req_type_o, mem_req_addr_o[31:0]}, 0);
    chk({busy_o, err_o, ic_rtrn_vld_o, dc_rtrn_vld_o} == 0, "idle_status",
        {busy_o, err_o, ic_rtrn_vld_o, dc_rtrn_vld_o}, 0);
  endtask

  initial begin
    int k;
    rst = 1; ready = 1; rsp_valid = 0; rsp_tag = '0; rsp_data = '0;
    repeat (3) cyc();
    rst = 0;
    check_idle();

    // 1: single I$ refill and its return
    cyc();
    push_ic(64'h8000_0040, 2'd0);
    wait_issued(1);
    cyc();
    send_rsp(issued[0], {16{8'hA5}});
    repeat (2) cyc();

    // 2: both caches requesting every cycle, immediate responses
    for (int i = 0; i < 16; i++) begin
      if (ic_q.size() < 1) push_ic({$urandom(), 26'($urandom()), 6'd0}, TW'(i));
      if (dc_q.size() < 1) push_dc(2'b00, TW'(i));
      cyc();
      if (issued.size() != 0) send_rsp(issued[0], rnd_line());
    end
    drain();

    // 3: fill the table with stores; fifth waits until tag 2 frees
    for (int i = 0; i < 5; i++) push_dc(2'b01, TW'(i));
    repeat (10) cyc();
    send_rsp(2'd2, rnd_line());
    repeat (3) cyc();
    drain();

    // 4: downstream stall with a load parked in the register
    ready = 0;
    push_dc(2'b00, 2'd1);
    repeat (2) cyc();
    push_ic(64'h1000, 2'd2);
    repeat (5) cyc();
    drain();

    // 5: response for an unallocated tag
    cyc();
    send_rsp(2'd3, rnd_line());
    repeat (3) cyc();

    // 6: reset with transactions outstanding
    for (int i = 0; i < 3; i++) push_dc(2'b00, TW'(i));
    wait_issued(3);
    rst = 1; ic_q.delete(); dc_q.delete();
    cyc();
    rst = 0;
    check_idle();
    cyc();
    push_ic(64'h2000, 2'd3);
    wait_issued(1);
    drain();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      cyc();
      ready = ($urandom_range(3) != 0);
      if (ic_q.size() < 2 && $urandom_range(2) == 0) push_ic({$urandom(), 26'($urandom()), 6'd0}, TW'($urandom()));
      if (dc_q.size() < 2 && $urandom_range(2) == 0) push_dc(2'($urandom_range(3)), TW'($urandom()));
      if (issued.size() != 0 && $urandom_range(1) == 1) begin
        k = $urandom_range(issued.size() - 1);
        send_rsp(issued[k], rnd_line());
      end
    end
    drain();
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
